memory_port_arbiter: RTL and testbench

Arbitrates a single-ported unified memory between the instruction-fetch port (IF stage) and the data-memory port (MEM stage) of the 5-stage pipelined processor. It sequences each access through a fixed-latency memory and returns read data or write acknowledgement to the requester. It drives a pipeline `stall` that the hazard logic ORs into PCWrite/IF_ID_Write gating. Data accesses win conflicts, and instruction fetch is never starved.

---
 rtl/memory_port_arbiter_pkg.sv | 22 ++
 rtl/memory_port_arbiter_wait_counter.sv | 33 +++
 rtl/memory_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_port_arbiter_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
// Imported by the arbiter top and its wait counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DATA_WAIT = 2'd1,
        ST_INST_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

    // Width needed to hold the values 0..wait_states.
    function automatic int cnt_width(input int wait_states);
        return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
    endfunction

endpackage

// File: rtl/memory_port_arbiter_wait_counter.sv
// Loadable down-counter that times the fixed memory latency.
// Reloaded only at grant, so it rests at zero instead of wrapping.
module mem_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int  WAIT_STATES = 2,
    localparam int CNT_W       = cnt_width(WAIT_STATES)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done
);

    logic [CNT_W-1:0] r_count;

    // Load on grant, otherwise count down while waiting and hold at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_W'(WAIT_STATES);
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates one unified memory between instruction fetch and data access,
// with round-robin on conflict (data first after reset) and a pipeline stall.
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              proto_err
);

    arb_state_t        r_state, w_state_nxt;
    grant_t            r_last_grant, w_last_grant_nxt;
    logic              w_dm_req, w_grant_data, w_grant_inst, w_done;
    logic              w_cap_inst, w_cap_data;
    logic              r_mem_en, r_mem_we, r_if_ready, r_dm_ready, r_proto_err;
    logic              w_mem_en_nxt, w_mem_we_nxt, w_if_ready_nxt, w_dm_ready_nxt, w_proto_err_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt, r_dm_rdata, w_dm_rdata_nxt;

    assign w_dm_req   = dm_read | dm_write;
    assign w_cap_inst = (r_state == ST_INST_WAIT) && w_done;
    assign w_cap_data = (r_state == ST_DATA_WAIT) && w_done;

    mem_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_grant_data | w_grant_inst),
        .i_dec  ((r_state == ST_DATA_WAIT) || (r_state == ST_INST_WAIT)),
        .o_done (w_done)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and grant decision; data wins a conflict unless it won the last one.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_data = 1'b0;
        w_grant_inst = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_dm_req && (!if_req || (r_last_grant == GNT_INST))) begin
                    w_grant_data = 1'b1;
                    w_state_nxt  = ST_DATA_WAIT;
                end else if (if_req) begin
                    w_grant_inst = 1'b1;
                    w_state_nxt  = ST_INST_WAIT;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_DATA_WAIT, ST_INST_WAIT: begin
                if (w_done) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; request inputs matter only at grant.
    always_comb begin
        w_mem_en_nxt     = w_grant_data | w_grant_inst;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_last_grant_nxt = r_last_grant;
        if (w_grant_data) begin
            w_mem_we_nxt     = dm_write;
            w_mem_addr_nxt   = dm_addr;
            w_mem_wdata_nxt  = dm_wdata;
            w_last_grant_nxt = GNT_DATA;
        end else if (w_grant_inst) begin
            w_mem_we_nxt     = 1'b0;
            w_mem_addr_nxt   = if_addr;
            w_mem_wdata_nxt  = r_mem_wdata;
            w_last_grant_nxt = GNT_INST;
        end else begin
            w_mem_we_nxt     = r_mem_we;
            w_last_grant_nxt = r_last_grant;
        end
        w_if_ready_nxt  = w_cap_inst;
        w_dm_ready_nxt  = w_cap_data;
        w_if_rdata_nxt  = w_cap_inst ? mem_rdata : r_if_rdata;
        w_dm_rdata_nxt  = (w_cap_data && !r_mem_we) ? mem_rdata : r_dm_rdata;
        w_proto_err_nxt = r_proto_err | (dm_read & dm_write);
    end

    // Output and grant-history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_ready   <= 1'b0;
            r_dm_ready   <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_proto_err  <= 1'b0;
            r_last_grant <= GNT_INST;
        end else begin
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_if_ready   <= w_if_ready_nxt;
            r_dm_ready   <= w_dm_ready_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_dm_rdata   <= w_dm_rdata_nxt;
            r_proto_err  <= w_proto_err_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign proto_err = r_proto_err;
    assign stall     = (if_req & ~r_if_ready) | (w_dm_req & ~r_dm_ready);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: table-driven accesses with a
// response scoreboard, plus contention, reset, protocol-error and latency builds.
module tb_memory_port_arbiter;
    import mem_arb_pkg::*;

    localparam int W     = 2;
    localparam int OP_IF = 0;
    localparam int OP_LD = 1;
    localparam int OP_ST = 2;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        is_data;
        logic        chk_data;
        logic [31:0] rdata;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_read, dm_write;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_en, mem_we, stall, proto_err;

    logic        w1_req, w1_ready, w1_dm_ready, w1_mem_en, w1_mem_we, w1_stall, w1_perr;
    logic [31:0] w1_addr, w1_if_rdata, w1_dm_rdata, w1_mem_addr, w1_mem_wdata;
    logic [31:0] w1_mem_rdata = 32'h1111_0001;
    logic        w15_req, w15_ready, w15_dm_ready, w15_mem_en, w15_mem_we, w15_stall, w15_perr;
    logic [31:0] w15_addr, w15_if_rdata, w15_dm_rdata, w15_mem_addr, w15_mem_wdata;
    logic [31:0] w15_mem_rdata = 32'h1515_000F;
    logic        tie0 = 1'b0;
    logic [31:0] tie0_32 = 32'h0000_0000;

    int   checks   = 0;
    int   failures = 0;
    sb_t  sb_q[$];
    logic cnt_bad = 1'b0;

    logic [31:0] mem [0:63];
    logic        rd_pend;
    int          rd_cnt;
    logic [5:0]  rd_idx;

    always #5 clk = ~clk;

    memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(W)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall), .proto_err(proto_err)
    );

    memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(1)) dut_w1 (
        .clk(clk), .reset(reset),
        .if_req(w1_req), .if_addr(w1_addr), .if_rdata(w1_if_rdata), .if_ready(w1_ready),
        .dm_read(tie0), .dm_write(tie0), .dm_addr(tie0_32), .dm_wdata(tie0_32),
        .dm_rdata(w1_dm_rdata), .dm_ready(w1_dm_ready),
        .mem_en(w1_mem_en), .mem_we(w1_mem_we), .mem_addr(w1_mem_addr), .mem_wdata(w1_mem_wdata),
        .mem_rdata(w1_mem_rdata), .stall(w1_stall), .proto_err(w1_perr)
    );

    memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(15)) dut_w15 (
        .clk(clk), .reset(reset),
        .if_req(w15_req), .if_addr(w15_addr), .if_rdata(w15_if_rdata), .if_ready(w15_ready),
        .dm_read(tie0), .dm_write(tie0), .dm_addr(tie0_32), .dm_wdata(tie0_32),
        .dm_rdata(w15_dm_rdata), .dm_ready(w15_dm_ready),
        .mem_en(w15_mem_en), .mem_we(w15_mem_we), .mem_addr(w15_mem_addr), .mem_wdata(w15_mem_wdata),
        .mem_rdata(w15_mem_rdata), .stall(w15_stall), .proto_err(w15_perr)
    );

    // Memory model: read data is valid only in the single cycle W cycles after mem_en.
    always @(posedge clk) begin
        if (reset) begin
            mem[4]  <= 32'h1111_2222;
            mem[16] <= 32'h8C01_0004;
            mem[17] <= 32'h0000_0013;
            rd_pend <= 1'b0;
            rd_cnt  <= 0;
        end else begin
            if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            if (mem_en && !mem_we) begin
                rd_pend <= 1'b1;
                rd_cnt  <= W - 1;
                rd_idx  <= mem_addr[7:2];
            end else if (rd_pend && rd_cnt == 0) begin
                rd_pend <= 1'b0;
            end else if (rd_pend) begin
                rd_cnt  <= rd_cnt - 1;
            end
        end
    end
    assign mem_rdata = (rd_pend && rd_cnt == 0) ? mem[rd_idx] : 32'hBAAD_F00D;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every ready pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        sb_t e;
        if (!reset && (if_ready || dm_ready)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ready", {30'd0, dm_ready, if_ready}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_port", {30'd0, dm_ready, if_ready}, e.is_data ? 32'd2 : 32'd1);
                if (e.chk_data) chk("sb_rdata", e.is_data ? dm_rdata : if_rdata, e.rdata);
            end
        end
    end

    // Counter range watch: an underflow would wrap above the loaded value.
    always @(negedge clk) begin
        if (int'(dut.u_cnt.r_count) > W || int'(dut_w1.u_cnt.r_count) > 1)
            cnt_bad <= 1'b1;
    end

    task automatic drop_all();
        if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 1;
        while (!(if_ready || dm_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  n;
        sb_t e;
        @(negedge clk);
        case (v.op)
            OP_IF:   begin if_req = 1'b1; if_addr = v.addr; end
            OP_LD:   begin dm_read = 1'b1; dm_addr = v.addr; end
            default: begin dm_write = 1'b1; dm_addr = v.addr; dm_wdata = v.wdata; end
        endcase
        e.is_data  = (v.op != OP_IF);
        e.chk_data = (v.op != OP_ST);
        e.rdata    = v.exp_rdata;
        sb_q.push_back(e);
        @(negedge clk);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd1);
        chk({tag, "_mem_we"}, 32'(mem_we), (v.op == OP_ST) ? 32'd1 : 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, v.addr);
        if (v.op == OP_ST) chk({tag, "_mem_wdata"}, mem_wdata, v.wdata);
        chk({tag, "_stall_busy"}, 32'(stall), 32'd1);
        wait_ready(n);
        chk({tag, "_latency"}, n, W + 2);
        chk({tag, "_stall_at_ready"}, 32'(stall), 32'd0);
        drop_all();
    endtask

    vec_t vecs[7];
    int   t_rdy[4];

    initial begin
        int  n, k;
        logic seen;
        sb_t e;

        vecs[0] = '{OP_IF, 32'h0000_0040, 32'h0,          32'h8C01_0004};
        vecs[1] = '{OP_ST, 32'h0000_0010, 32'hDEAD_BEEF,  32'h0};
        vecs[2] = '{OP_LD, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF};
        vecs[3] = '{OP_ST, 32'h0000_0014, 32'h1234_5678,  32'h0};
        vecs[4] = '{OP_IF, 32'h0000_0014, 32'h0,          32'h1234_5678};
        vecs[5] = '{OP_LD, 32'h0000_0040, 32'h0,          32'h8C01_0004};
        vecs[6] = '{OP_IF, 32'h0000_0044, 32'h0,          32'h0000_0013};

        reset = 1'b1;
        drop_all();
        if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        w1_req = 1'b0; w1_addr = 32'h0; w15_req = 1'b0; w15_addr = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_ready", {30'd0, dm_ready, if_ready}, 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_stall_idle", 32'(stall), 32'd0);

        // Contention held from reset: DATA, INST, DATA, INST, W+3 apart.
        if_req = 1'b1; if_addr = 32'h0000_0040; dm_read = 1'b1; dm_addr = 32'h0000_0010;
        for (int i = 0; i < 4; i++) begin
            e.is_data  = (i % 2 == 0);
            e.chk_data = 1'b1;
            e.rdata    = (i % 2 == 0) ? 32'h1111_2222 : 32'h8C01_0004;
            sb_q.push_back(e);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0; k = 0;
        while (k < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (if_ready || dm_ready) begin
                t_rdy[k] = n;
                k++;
            end
        end
        drop_all();
        chk("cont_count", k, 4);
        chk("cont_first_latency", t_rdy[0], W + 2);
        for (int i = 1; i < 4; i++)
            chk($sformatf("cont_spacing%0d", i), t_rdy[i] - t_rdy[i-1], W + 3);

        // Reset in the middle of a fetch aborts it silently.
        @(negedge clk);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0044;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_if_rdata", if_rdata, 32'd0);
        chk("midrst_state", 32'(dut.r_state), 32'(ST_IDLE));
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (if_ready || dm_ready) seen = 1'b1;
        end
        chk("midrst_no_ready", 32'(seen), 32'd0);

        // Table of single accesses.
        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // Read and write together: handled as a write, sticky error.
        @(negedge clk);
        dm_read = 1'b1; dm_write = 1'b1; dm_addr = 32'h0000_0018; dm_wdata = 32'hCAFE_F00D;
        e.is_data = 1'b1; e.chk_data = 1'b0; e.rdata = 32'h0;
        sb_q.push_back(e);
        @(negedge clk);
        chk("perr_mem_we", 32'(mem_we), 32'd1);
        chk("perr_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        wait_ready(n);
        chk("perr_latency", n, W + 2);
        drop_all();
        @(negedge clk);
        chk("perr_set", 32'(proto_err), 32'd1);
        run_vec('{OP_LD, 32'h0000_0018, 32'h0, 32'hCAFE_F00D}, "perr_load");
        chk("perr_sticky", 32'(proto_err), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("perr_cleared", 32'(proto_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Latency at the extremes of the wait-state range.
        @(negedge clk);
        w1_req = 1'b1; w1_addr = 32'h0000_0080;
        @(negedge clk);
        chk("w1_mem_addr", w1_mem_addr, 32'h0000_0080);
        n = 1;
        while (!w1_ready && n < 40) begin @(negedge clk); n++; end
        chk("w1_latency", n, 3);
        chk("w1_rdata", w1_if_rdata, 32'h1111_0001);
        w1_req = 1'b0;

        @(negedge clk);
        w15_req = 1'b1; w15_addr = 32'h0000_00C0;
        @(negedge clk);
        chk("w15_mem_en", 32'(w15_mem_en), 32'd1);
        n = 1;
        while (!w15_ready && n < 40) begin @(negedge clk); n++; end
        chk("w15_latency", n, 17);
        chk("w15_rdata", w15_if_rdata, 32'h1515_000F);
        w15_req = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("cnt_range", 32'(cnt_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
